// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the hazard/stall controller and its mul/div countdown.
package hazard_stall_ctrl_pkg;

  localparam int unsigned MD_CYCLES_DEF = 32;
  localparam int unsigned REG_W         = 5;
  localparam int unsigned MD_CNT_W      = 6;
  localparam int unsigned STALL_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Destination rw feeds the ID instruction; r0 is never a real producer.
  function automatic logic reg_hit(input logic [REG_W-1:0] rw,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rt,
                                   input logic             use_rt);
    return (rw != '0) && ((rw == rs) || (use_rt && (rw == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_cycle_counter.sv
// Mul/div latency countdown: loadable down-counter with a registered zero flag.
module md_cycle_counter
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned W = MD_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q, zero_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
    zero_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard detection and stall/flush control with a mul/div occupancy FSM.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_W-1:0]       rs_reg,
  input  logic [REG_W-1:0]       rt_reg,
  input  logic                   UseRt_ID,
  input  logic                   Branch_ID,
  input  logic                   BranchTaken_ID,
  input  logic                   MulDiv_ID,
  input  logic                   MfHiLo_ID,
  input  logic [REG_W-1:0]       rw_IDEx,
  input  logic [REG_W-1:0]       rw_ExMem,
  input  logic                   RegWr_IDEx,
  input  logic                   MemRead_IDEx,
  input  logic                   MemRead_ExMem,
  output logic                   PCWr,
  output logic                   IFIDWr,
  output logic                   IDExFlush,
  output logic                   IFIDFlush,
  output logic                   MDBusy,
  output logic                   MdStart,
  output logic [STALL_CNT_W-1:0] StallCount
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_CYCLES - 1);

  md_state_e              state_q, state_d;
  logic                   md_start_q, md_start_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   cnt_load, cnt_dec, md_zero;
  logic                   load_use, br_haz, md_haz, stall;

  // Branches compare in ID, so any in-flight producer of rs/rt blocks them.
  always_comb begin
    load_use = MemRead_IDEx && reg_hit(rw_IDEx, rs_reg, rt_reg, UseRt_ID);
    br_haz   = Branch_ID &&
               ((RegWr_IDEx    && reg_hit(rw_IDEx,  rs_reg, rt_reg, 1'b1)) ||
                (MemRead_ExMem && reg_hit(rw_ExMem, rs_reg, rt_reg, 1'b1)));
    md_haz   = (MulDiv_ID || MfHiLo_ID) && (state_q != IDLE);
    stall    = load_use || br_haz || md_haz;
  end

  // Mul/div occupancy: HI/LO are only safe again once MD_DONE has passed.
  always_comb begin
    state_d    = state_q;
    md_start_d = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MulDiv_ID && !stall) begin
          state_d    = MD_BUSY;
          md_start_d = 1'b1;
          cnt_load   = 1'b1;
        end
      end
      MD_BUSY: begin
        if (md_zero) begin
          state_d = MD_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      MD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      md_start_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_start_q  <= md_start_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  md_cycle_counter #(
    .W (MD_CNT_W)
  ) u_md_cycle_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (MD_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (md_zero)
  );

  // Pipeline controls must act in the same cycle the hazard is seen.
  assign PCWr       = !stall;
  assign IFIDWr     = !stall;
  assign IDExFlush  = stall;
  assign IFIDFlush  = BranchTaken_ID && !stall;
  assign MDBusy     = (state_q != IDLE);
  assign MdStart    = md_start_q;
  assign StallCount = stall_cnt_q;

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter: MD_CYCLES, default 32, execution latency of a mul/div operation in cycles (legal range 2..63).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: rs_reg, rt_reg  input  5 each  source registers of the instruction in ID.
REQ-005 Port: UseRt_ID  input  1  ID instruction reads rt.
REQ-006 Port: Branch_ID  input  1  ID instruction is a branch or jr, compared in ID.
REQ-007 Port: BranchTaken_ID  input  1  branch resolved taken in ID.
REQ-008 Port: MulDiv_ID, MfHiLo_ID  input  1 each  ID instruction starts a mul/div; ID instruction reads HI/LO.
REQ-009 Port: rw_IDEx, rw_ExMem  input  5 each  destination registers in EX and MEM.
REQ-010 Port: RegWr_IDEx, MemRead_IDEx, MemRead_ExMem  input  1 each  write-enable and load flags for EX and MEM.
REQ-011 Port: PCWr, IFIDWr  output  1 each  PC and IF/ID register write enables.
REQ-012 Port: IDExFlush, IFIDFlush  output  1 each  insert a bubble into ID/EX; squash IF/ID.
REQ-013 Port: MDBusy  output  1  mul/div unit is occupied.
REQ-014 Port: MdStart  output  1  one-cycle pulse launching the mul/div unit.
REQ-015 Port: StallCount  output  16  saturating count of stall cycles.

Function
REQ-016 load_use SHALL be MemRead_IDEx & rw_IDEx!=0 & (rw_IDEx==rs_reg | UseRt_ID & rw_IDEx==rt_reg).
REQ-017 br_haz SHALL be Branch_ID & ((RegWr_IDEx & rw_IDEx!=0 & rw_IDEx matches rs_reg/rt_reg) | (MemRead_ExMem & rw_ExMem!=0 & rw_ExMem matches rs_reg/rt_reg)). A load feeding a branch therefore stalls two cycles.
REQ-018 md_haz SHALL be (MulDiv_ID | MfHiLo_ID) & state!=IDLE.
REQ-019 stall = load_use | br_haz | md_haz, combinational from inputs and registered state, same cycle.
REQ-020 When stall=1: PCWr=0, IFIDWr=0, IDExFlush=1, IFIDFlush=0. Otherwise PCWr=1, IFIDWr=1, IDExFlush=0.
REQ-021 IFIDFlush SHALL be BranchTaken_ID & !stall. Stall has priority and suppresses the flush.
REQ-022 FSM states: IDLE, MD_BUSY, MD_DONE.
REQ-023 IDLE->MD_BUSY when MulDiv_ID & !stall. MdStart=1 in that cycle only, and the cycle counter loads MD_CYCLES-1.
REQ-024 In MD_BUSY the counter decrements each cycle. At counter==0 the FSM moves to MD_DONE.
REQ-025 In MD_DONE (one cycle, HI/LO written) the FSM moves to IDLE. md_haz still applies in MD_DONE.
REQ-026 A MulDiv_ID presented while not IDLE SHALL stall and SHALL NOT restart the counter. It is accepted on the first IDLE cycle.
REQ-027 MDBusy = (state!=IDLE).
REQ-028 StallCount SHALL increment by 1 on each stall cycle and saturate at 16'hFFFF without wrap.
REQ-029 rw=0 never causes a hazard. Simultaneous load_use and br_haz count as one stall cycle.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, counter=0, StallCount=0, MdStart=0.
REQ-031 With inputs idle after reset, outputs SHALL be PCWr=1, IFIDWr=1, IDExFlush=0, IFIDFlush=0, MDBusy=0.
REQ-032 Reset asserted mid mul/div SHALL abandon the operation. No MD_DONE cycle follows.

Structure
REQ-033 State encoding (IDLE=2'd0, MD_BUSY=2'd1, MD_DONE=2'd2) and the MD_CYCLES default SHALL live in a shared package.
REQ-034 The mul/div countdown SHALL be one sub-module, md_cycle_counter (load, decrement, zero flag). Hazard detection stays inline.

Verification
REQ-035 Load r5 in EX, ID reads rs=5 -> exactly 1 cycle with PCWr=0 and IDExFlush=1, then StallCount=1.
REQ-036 Load r8 in EX, ID beq rs=8 -> 2 stall cycles, then BranchTaken_ID=1 gives IFIDFlush=1 for 1 cycle. StallCount=2.
REQ-037 MulDiv_ID with MD_CYCLES=4, then mflo in ID the next cycle -> MdStart pulses once, MDBusy high 5 cycles, mflo stalls 5 cycles and issues when IDLE.
REQ-038 Second MulDiv_ID during MD_BUSY -> stalls, no second MdStart until IDLE, then exactly one MdStart.
REQ-039 rw_IDEx=0 with MemRead_IDEx=1 and rs_reg=0 -> no stall. BranchTaken_ID during load_use -> IFIDFlush=0.
REQ-040 rst_n low mid MD_BUSY -> MDBusy=0 immediately. 65540 consecutive stall cycles -> StallCount=16'hFFFF.
